// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and state encoding for the ALU UART sequencer
//
// Purpose: default widths, ALU opcode values and the sequencer state
// encoding, shared by alu_uart_if and alu_if_timer.
// Ports: none (package).

package alu_pkg;

  localparam int BUS_SIZE_DEF       = 8;
  localparam int OPCODE_SIZE_DEF    = 6;
  localparam int TIMEOUT_CYCLES_DEF = 1000000;

  // ALU opcodes carried in the low OPCODE_SIZE bits of the third frame byte
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_B    = 3'd1,
    ST_WAIT_OP   = 3'd2,
    ST_EXEC      = 3'd3,
    ST_TX_RES    = 3'd4,
    ST_WAIT_RES  = 3'd5,
    ST_TX_STAT   = 3'd6,
    ST_WAIT_STAT = 3'd7
  } alu_if_state_e;

endpackage

// File: rtl/alu_if_timer.sv
// rtl/alu_if_timer.sv - inter-byte idle counter with clear and expire flag
//
// Purpose: counts enabled cycles since the last clear; o_expire is high while
// enabled and the count has reached TIMEOUT_CYCLES-1.
// Ports:
//   i_clock    clock
//   i_reset_n  asynchronous active-low reset
//   i_clear    restart the count at 0 on the next edge
//   i_enable   count this cycle (count holds when low)
//   o_expire   idle limit reached while enabled

module alu_if_timer
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable && (count_q != LAST)) begin
      // saturate at LAST so a held enable never wraps back to zero
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expire = i_enable && (count_q == LAST);

endmodule

// File: rtl/alu_uart_if.sv
// rtl/alu_uart_if.sv - UART frame sequencer feeding a combinational ALU
//
// Purpose: collects operand A, operand B and opcode bytes from a UART
// receiver, presents them to the ALU, then returns the result byte and a
// status byte (carry in bit 0) through the UART transmitter.
// Ports:
//   i_clock, i_reset_n        clock, asynchronous active-low reset
//   i_rx_data, i_rx_done      received byte and its one-cycle strobe
//   i_tx_done                 transmitter finished the current byte
//   i_alu_result, i_alu_carry combinational ALU outputs
//   o_alu_a, o_alu_b, o_alu_op ALU operand and opcode registers
//   o_tx_start, o_tx_data     transmit strobe and byte
//   o_busy                    not idle
//   o_overrun                 sticky: a byte arrived during execute/transmit
//   o_timeout                 one-cycle pulse when a partial frame is dropped

module alu_uart_if
  import alu_pkg::*;
#(
  parameter int BUS_SIZE       = BUS_SIZE_DEF,
  parameter int OPCODE_SIZE    = OPCODE_SIZE_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic [BUS_SIZE-1:0]    i_rx_data,
  input  logic                   i_rx_done,
  input  logic                   i_tx_done,
  input  logic [BUS_SIZE-1:0]    i_alu_result,
  input  logic                   i_alu_carry,
  output logic [BUS_SIZE-1:0]    o_alu_a,
  output logic [BUS_SIZE-1:0]    o_alu_b,
  output logic [OPCODE_SIZE-1:0] o_alu_op,
  output logic                   o_tx_start,
  output logic [BUS_SIZE-1:0]    o_tx_data,
  output logic                   o_busy,
  output logic                   o_overrun,
  output logic                   o_timeout
);

  alu_if_state_e state_q, state_d;

  logic [BUS_SIZE-1:0]    alu_a_q, alu_a_d;
  logic [BUS_SIZE-1:0]    alu_b_q, alu_b_d;
  logic [OPCODE_SIZE-1:0] alu_op_q, alu_op_d;
  logic [BUS_SIZE-1:0]    tx_data_q, tx_data_d;
  logic                   carry_q, carry_d;
  logic                   overrun_q, overrun_d;
  logic                   timeout_q, timeout_d;

  logic timer_clear;
  logic timer_enable;
  logic timer_expire;

  // Only the receive-side waits are bounded; a stalled transmitter is not
  // this block's to abandon.
  assign timer_enable = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
  assign timer_clear  = i_rx_done || (state_d != state_q);

  alu_if_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clear   (timer_clear),
    .i_enable  (timer_enable),
    .o_expire  (timer_expire)
  );

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    tx_data_d = tx_data_q;
    carry_d   = carry_q;
    overrun_d = overrun_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_rx_done) begin
          alu_a_d = i_rx_data;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        // a byte landing on the expiry cycle still counts
        if (i_rx_done) begin
          alu_b_d = i_rx_data;
          state_d = ST_WAIT_OP;
        end else if (timer_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done) begin
          alu_op_d = i_rx_data[OPCODE_SIZE-1:0];
          state_d  = ST_EXEC;
        end else if (timer_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // operands have been stable for a full cycle; sample the ALU
        tx_data_d = i_alu_result;
        carry_d   = i_alu_carry;
        state_d   = ST_TX_RES;
      end
      ST_TX_RES: begin
        state_d = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (i_tx_done) begin
          tx_data_d = {{(BUS_SIZE-1){1'b0}}, carry_q};
          state_d   = ST_TX_STAT;
        end
      end
      ST_TX_STAT: begin
        state_d = ST_WAIT_STAT;
      end
      ST_WAIT_STAT: begin
        if (i_tx_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bytes arriving once the frame is complete are dropped but flagged.
    if (i_rx_done && (state_q != ST_IDLE) && (state_q != ST_WAIT_B) &&
        (state_q != ST_WAIT_OP)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      tx_data_q <= '0;
      carry_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      tx_data_q <= tx_data_d;
      carry_q   <= carry_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  // Strobes decode straight from state so reset silences them immediately.
  assign o_tx_start = (state_q == ST_TX_RES) || (state_q == ST_TX_STAT);
  assign o_busy     = (state_q != ST_IDLE);
  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_data  = tx_data_q;
  assign o_overrun  = overrun_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_alu_uart_if.sv
// tb/tb_alu_uart_if.sv - self-checking bench for alu_uart_if

module tb_alu_uart_if;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       overrun;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  alu_uart_if #(
    .BUS_SIZE(8),
    .OPCODE_SIZE(6),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_tx_done    (tx_done),
    .i_alu_result (alu_result),
    .i_alu_carry  (alu_carry),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_op     (alu_op),
    .o_tx_start   (tx_start),
    .o_tx_data    (tx_data),
    .o_busy       (busy),
    .o_overrun    (overrun),
    .o_timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: {carry, result} using 9-bit arithmetic
  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    logic signed [7:0] sa;
    logic [7:0]        t;
    sa = a;
    case (op)
      OP_ADD: return {1'b0, a} + {1'b0, b};
      OP_SUB: return {1'b0, a} - {1'b0, b};
      OP_AND: return {1'b0, a & b};
      OP_OR:  return {1'b0, a | b};
      OP_XOR: return {1'b0, a ^ b};
      OP_NOR: return {1'b0, ~(a | b)};
      OP_SRL: return {1'b0, a >> b};
      OP_SRA: begin
        t = sa >>> b;
        return {1'b0, t};
      end
      default: return 9'd0;
    endcase
  endfunction

  always_comb {alu_carry, alu_result} = alu_ref(alu_a, alu_b, alu_op);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic wait_start(input string tag, output int k);
    k = 0;
    while (!tx_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!tx_start) check({tag, "_start_seen"}, 32'd0, 32'd1);
  endtask

  // Full frame: three rx bytes, two tx bytes; optional overrun injection in
  // WAIT_RES and optional reset in WAIT_STAT.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input logic [5:0] exp_op, input logic [7:0] exp_res,
                           input logic [7:0] exp_stat, input bit inject, input bit mid_reset);
    int k;
    int saw;
    send_byte(a);
    send_byte(b);
    send_byte(opb);
    check("exec_no_start", tx_start, 1'b0);
    wait_start("res", k);
    check("latency", k + 1, 2);
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_op", alu_op, exp_op);
    check("tx_res", tx_data, exp_res);
    @(negedge clk);
    check("start_one_cycle", tx_start, 1'b0);
    if (inject) begin
      send_byte(8'hAA);
      check("overrun_set", overrun, 1'b1);
      check("overrun_busy", busy, 1'b1);
    end
    repeat ($urandom_range(0, 4)) @(negedge clk);
    check("hold_res", tx_data, exp_res);
    pulse_tx_done();
    wait_start("stat", k);
    check("tx_stat", tx_data, exp_stat);
    @(negedge clk);
    check("stat_one_cycle", tx_start, 1'b0);
    if (mid_reset) begin
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_start", tx_start, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_alu_a", alu_a, 8'h00);
      check("rst_alu_op", alu_op, 6'h00);
      check("rst_overrun", overrun, 1'b0);
      saw = 0;
      repeat (3) begin
        @(negedge clk);
        if (tx_start) saw = 1;
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      rst_n = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (tx_start) saw = 1;
      end
      check("rst_no_start", saw, 0);
      check("rst_idle", busy, 1'b0);
    end else begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      pulse_tx_done();
      check("done_idle", busy, 1'b0);
      if (inject) begin
        check("overrun_sticky", overrun, 1'b1);
        check("alu_a_kept", alu_a, a);
      end
    end
  endtask

  initial begin
    int k;
    int saw;
    logic [5:0] ops [8];
    logic [7:0] ra, rb, rop;
    logic [8:0] exp;

    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND; ops[3] = OP_OR;
    ops[4] = OP_XOR; ops[5] = OP_NOR; ops[6] = OP_SRL; ops[7] = OP_SRA;

    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_start", tx_start, 1'b0);
    check("reset_tx_data", tx_data, 8'h00);
    check("reset_overrun", overrun, 1'b0);
    check("reset_timeout", timeout, 1'b0);
    rst_n = 1'b1;

    // directed frames
    run_frame(8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 8'h00, 0, 0);
    run_frame(8'hFF, 8'h01, 8'h20, 6'h20, 8'h00, 8'h01, 0, 0);
    run_frame(8'h03, 8'h05, 8'h22, 6'h22, 8'hFE, 8'h01, 0, 0);
    run_frame(8'hF0, 8'h0F, 8'hE5, 6'h25, 8'hFF, 8'h00, 0, 0);

    // timeout after one byte
    send_byte(8'h11);
    k = 0;
    saw = 0;
    while (!timeout && k < 40) begin
      @(negedge clk);
      k++;
      if (tx_start) saw = 1;
    end
    check("timeout_cycles", k, 16);
    check("timeout_idle", busy, 1'b0);
    check("timeout_no_start", saw, 0);
    check("timeout_alu_a", alu_a, 8'h11);
    @(negedge clk);
    check("timeout_pulse", timeout, 1'b0);
    run_frame(8'h02, 8'h02, 8'h20, 6'h20, 8'h04, 8'h00, 0, 0);

    // overrun during WAIT_RES
    run_frame(8'h40, 8'h22, 8'h26, 6'h26, 8'h62, 8'h00, 1, 0);

    // randomized frames against the reference ALU
    for (int i = 0; i < 12; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = {2'($urandom), ops[$urandom_range(0, 7)]};
      exp = alu_ref(ra, rb, rop[5:0]);
      run_frame(ra, rb, rop, rop[5:0], exp[7:0], {7'b0, exp[8]}, 0, 0);
    end

    // asynchronous reset in WAIT_STAT, then a clean frame
    run_frame(8'h09, 8'h07, 8'h22, 6'h22, 8'h02, 8'h00, 0, 1);
    run_frame(8'h80, 8'h80, 8'h20, 6'h20, 8'h00, 8'h01, 0, 0);
    check("post_reset_overrun", overrun, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/alu_uart_if.md
Name: alu_uart_if

Overview:
Sequencer between a UART receiver/transmitter pair and the combinational ALU. It collects three received bytes in order: operand A, operand B, opcode. It drives them onto the ALU inputs, captures the ALU result and carry, then sends two bytes back through the UART transmitter: the result byte, then a status byte. It replaces the button/switch operand loading for host-driven operation.

Parameters:
BUS_SIZE, 8, data width of operands, result and UART bytes
OPCODE_SIZE, 6, ALU opcode width; taken from the low bits of the third byte
TIMEOUT_CYCLES, 1000000, maximum idle clock cycles between bytes of one command frame

Ports:
i_clock  input  1  system clock, all logic on rising edge
i_reset_n  input  1  asynchronous active-low reset
i_rx_data  input  BUS_SIZE  byte from UART receiver, valid when i_rx_done=1
i_rx_done  input  1  one-cycle pulse, new byte on i_rx_data
i_tx_done  input  1  one-cycle pulse, transmitter finished the current byte
i_alu_result  input  BUS_SIZE  ALU result (combinational from o_alu_*)
i_alu_carry  input  1  ALU carry
o_alu_a  output  BUS_SIZE  operand A register
o_alu_b  output  BUS_SIZE  operand B register
o_alu_op  output  OPCODE_SIZE  opcode register
o_tx_start  output  1  one-cycle pulse, transmitter loads o_tx_data
o_tx_data  output  BUS_SIZE  byte to transmit, stable from the o_tx_start cycle until i_tx_done
o_busy  output  1  high in any state other than IDLE
o_overrun  output  1  sticky; a byte arrived while the block could not accept it
o_timeout  output  1  one-cycle pulse on frame abandonment

Behaviour:
- Reset is asynchronous and active-low. It clears all registers, sets state to IDLE and drives every output to 0. Reset mid-frame or mid-transmit abandons the frame; no tx pulse follows.
- States: IDLE, WAIT_B, WAIT_OP, EXEC, TX_RES, WAIT_RES, TX_STAT, WAIT_STAT.
- IDLE: on i_rx_done, o_alu_a <= i_rx_data and go to WAIT_B.
- WAIT_B: on i_rx_done, o_alu_b <= i_rx_data and go to WAIT_OP.
- WAIT_OP: on i_rx_done, o_alu_op <= i_rx_data[OPCODE_SIZE-1:0] (upper bits ignored) and go to EXEC.
- EXEC: lasts exactly one cycle, because the ALU is combinational. At the end of EXEC, latch i_alu_result into o_tx_data and latch i_alu_carry internally. Then go to TX_RES.
- TX_RES: o_tx_start=1 for exactly one cycle, then go to WAIT_RES.
- WAIT_RES: on i_tx_done, o_tx_data <= {zeros, carry} (carry in bit 0) and go to TX_STAT.
- TX_STAT: o_tx_start=1 for one cycle, then go to WAIT_STAT.
- WAIT_STAT: on i_tx_done, go to IDLE.
- Latency: the first o_tx_start occurs 2 cycles after the i_rx_done cycle of the opcode byte.
- Timeout:
  - A counter clears on every i_rx_done and on every state change.
  - It counts only in WAIT_B and WAIT_OP.
  - When it reaches TIMEOUT_CYCLES-1 without a byte, the block returns to IDLE and pulses o_timeout.
  - o_alu_a/b/op keep their last values.
  - If i_rx_done and expiry fall in the same cycle, i_rx_done wins.
- Overrun:
  - i_rx_done in EXEC, TX_*, or WAIT_* (transmit side) sets o_overrun.
  - The byte is dropped and the state is unaffected.
  - o_overrun clears only on reset.
- If i_tx_done arrives while not in WAIT_RES/WAIT_STAT, it is ignored.
- o_alu_* change only on the accepting i_rx_done edge, so the ALU inputs are glitch-free during EXEC.
- Arithmetic is entirely in the ALU; this block does no width extension.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU opcode localparams ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRL 000010, SRA 000011;
  - the state encoding constants;
  - the BUS_SIZE/OPCODE_SIZE defaults.
- One sub-module is natural: alu_if_timer (loadable down/up counter with clear and expire pulse), parameterised by TIMEOUT_CYCLES.
- The FSM and datapath registers stay in alu_uart_if.

Test Plan:
1. ADD: rx bytes 0x05, 0x03, 0x20 with ALU model attached. Expect o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20, o_tx_start 2 cycles after the third rx_done with o_tx_data=0x08. After tx_done, a second o_tx_start with 0x00; after the second tx_done, o_busy=0.
2. Carry/SUB: rx 0xFF, 0x01, 0x20 -> tx 0x00 then 0x01. Rx 0x03, 0x05, 0x22 -> tx 0xFE then 0x01 (borrow out in bit 8).
3. Upper opcode bits: rx 0xF0, 0x0F, 0xE5 -> o_alu_op=0x25 (OR), tx 0xFF then 0x00.
4. Timeout: TIMEOUT_CYCLES=16. Send 0x11, then nothing -> o_timeout pulses once after 16 idle cycles, state returns to IDLE, no o_tx_start. A next frame 0x02, 0x02, 0x20 -> tx 0x04.
5. Overrun: inject rx_done 0xAA during WAIT_RES -> o_overrun=1 and stays 1; the frame completes normally and o_alu_a is unchanged.
6. Async reset: assert i_reset_n=0 mid-WAIT_STAT, between clock edges -> all outputs 0 immediately, with no further o_tx_start. After release, a full frame works and o_overrun=0.
